channel_hop_selector: RTL and testbench

Parametrised successor to the team's single-cycle least-jammed-channel picker. Accumulates per-channel jammer energy over a window of sample vectors and averages it. Then scans for the minimum and applies hysteresis plus a minimum dwell before hopping the comms link. Sits between the jammer energy detectors and the link controller's hop logic.

---
 rtl/chan_sel_pkg.sv | 28 ++
 rtl/energy_accum_bank.sv | 43 ++++
 rtl/channel_hop_selector.sv | 144 ++++++++++++++
 tb/tb_channel_hop_selector.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/chan_sel_pkg.sv
// Shared types and width helpers for the channel hop selector.
package chan_sel_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_ENERGY_W  = 8;
  localparam int DEF_WIN_LOG2  = 2;
  localparam int DEF_HYST      = 4;
  localparam int DEF_MIN_DWELL = 2;

  localparam int DEF_ACC_W   = DEF_ENERGY_W + DEF_WIN_LOG2;
  localparam int DEF_DWELL_W = $clog2(DEF_MIN_DWELL + 1);

  // Accumulator holds 2**win_log2 full-scale samples without overflow.
  function automatic int acc_width(input int energy_w, input int win_log2);
    return energy_w + win_log2;
  endfunction

  function automatic int dwell_width(input int min_dwell);
    return (min_dwell < 1) ? 1 : $clog2(min_dwell + 1);
  endfunction

endpackage

// File: rtl/energy_accum_bank.sv
// Per-channel energy accumulators with a synchronous clear and an indexed
// windowed-average read port used by the scan.
module energy_accum_bank
  import chan_sel_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ENERGY_W = DEF_ENERGY_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         add,
  input  logic                         clear,
  input  logic [NUM_CH*ENERGY_W-1:0]   sample_energy,
  input  logic [CH_W-1:0]              rd_idx,
  output logic [ENERGY_W-1:0]          rd_avg
);

  localparam int ACC_W = acc_width(ENERGY_W, WIN_LOG2);

  logic [ACC_W-1:0] acc [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (add) begin
      for (int i = 0; i < NUM_CH; i++)
        acc[i] <= acc[i] + ACC_W'(sample_energy[i*ENERGY_W +: ENERGY_W]);
    end
  end

  // Floor average; out-of-range indices (non power-of-two NUM_CH) read 0.
  always_comb begin
    rd_avg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == rd_idx) rd_avg = ENERGY_W'(acc[i] >> WIN_LOG2);
    end
  end

endmodule

// File: rtl/channel_hop_selector.sv
// Windowed least-jammed channel selector with hysteresis and minimum dwell
// before hopping the link to a new channel.
module channel_hop_selector
  import chan_sel_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ENERGY_W  = DEF_ENERGY_W,
  parameter int WIN_LOG2  = DEF_WIN_LOG2,
  parameter int HYST      = DEF_HYST,
  parameter int MIN_DWELL = DEF_MIN_DWELL,
  parameter int CH_W      = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [NUM_CH*ENERGY_W-1:0]  sample_energy,
  output logic                        sample_ready,
  output logic [CH_W-1:0]             safest_channel,
  output logic                        channel_valid,
  output logic [ENERGY_W-1:0]         best_energy,
  output logic                        hop_pulse
);

  localparam int DWELL_W = dwell_width(MIN_DWELL);
  localparam logic [ENERGY_W:0]  HYST_V      = (ENERGY_W+1)'(HYST);
  localparam logic [DWELL_W-1:0] MIN_DWELL_V = DWELL_W'(MIN_DWELL);
  localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(NUM_CH - 1);

  state_t                state, state_nxt;
  logic [WIN_LOG2-1:0]   smp_cnt;
  logic [CH_W-1:0]       scan_idx;
  logic [CH_W-1:0]       best_idx;
  logic [ENERGY_W-1:0]   best_avg;
  logic [ENERGY_W-1:0]   cur_avg;
  logic [ENERGY_W-1:0]   rd_avg;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic                  accept;
  logic                  acc_add;
  logic                  acc_clear;
  logic                  win_last;
  logic                  scan_last;
  logic                  hop_ok;

  assign win_last  = (smp_cnt == '1);
  assign scan_last = (scan_idx == LAST_CH);

  energy_accum_bank #(
    .NUM_CH   (NUM_CH),
    .ENERGY_W (ENERGY_W),
    .WIN_LOG2 (WIN_LOG2),
    .CH_W     (CH_W)
  ) u_bank (
    .clk           (clk),
    .reset         (reset),
    .add           (acc_add),
    .clear         (acc_clear),
    .sample_energy (sample_energy),
    .rd_idx        (scan_idx),
    .rd_avg        (rd_avg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && win_last) state_nxt = SCAN;
      SCAN:    if (scan_last)          state_nxt = DECIDE;
      DECIDE:                          state_nxt = ACCUM;
      default:                         state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    sample_ready = 1'b0;
    accept       = 1'b0;
    acc_add      = 1'b0;
    acc_clear    = 1'b0;
    case (state)
      ACCUM: begin
        sample_ready = 1'b1;
        accept       = sample_valid;
        acc_add      = sample_valid;
      end
      DECIDE:  acc_clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       smp_cnt <= '0;
    else if (accept) smp_cnt <= smp_cnt + 1'b1;
  end

  // Scan: strict less-than so ties keep the lowest index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_avg <= '0;
      cur_avg  <= '0;
    end else if (state == SCAN) begin
      scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
      if (scan_idx == '0 || rd_avg < best_avg) begin
        best_idx <= scan_idx;
        best_avg <= rd_avg;
      end
      if (scan_idx == safest_channel) cur_avg <= rd_avg;
    end
  end

  // Hysteresis sum is one bit wider so best_avg + HYST never wraps.
  assign hop_ok = (best_idx != safest_channel) &&
                  (({1'b0, best_avg} + HYST_V) < {1'b0, cur_avg}) &&
                  (dwell_cnt >= MIN_DWELL_V);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      safest_channel <= '0;
      best_energy    <= '0;
      channel_valid  <= 1'b0;
      hop_pulse      <= 1'b0;
      dwell_cnt      <= '0;
    end else begin
      hop_pulse <= 1'b0;
      if (state == DECIDE) begin
        if (!channel_valid || hop_ok) begin
          safest_channel <= best_idx;
          best_energy    <= best_avg;
          channel_valid  <= 1'b1;
          hop_pulse      <= 1'b1;
          dwell_cnt      <= '0;
        end else begin
          best_energy <= cur_avg;
          if (dwell_cnt < MIN_DWELL_V) dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_hop_selector.sv
// Directed bench for channel_hop_selector (4 channels, 8-bit energy, window 4).
module tb_channel_hop_selector;

  localparam int NUM_CH = 4;
  localparam int EW     = 8;

  logic              clk;
  logic              reset;
  logic              sample_valid;
  logic [NUM_CH*EW-1:0] sample_energy;
  logic              sample_ready;
  logic [1:0]        safest_channel;
  logic              channel_valid;
  logic [EW-1:0]     best_energy;
  logic              hop_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  channel_hop_selector #(
    .NUM_CH(4), .ENERGY_W(8), .WIN_LOG2(2), .HYST(4), .MIN_DWELL(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample_energy  (sample_energy),
    .sample_ready   (sample_ready),
    .safest_channel (safest_channel),
    .channel_valid  (channel_valid),
    .best_energy    (best_energy),
    .hop_pulse      (hop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Four accepted samples, then wait to the negedge after the commit edge.
  task automatic send_window(input logic [31:0] s0, input logic [31:0] s1,
                             input logic [31:0] s2, input logic [31:0] s3);
    logic [31:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid  = 1'b1;
      sample_energy = s[i];
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_commit_hop", {31'd0, hop_pulse}, 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int ch, input int be, input int hp);
    chk({tag, "_ch"},  {30'd0, safest_channel}, 32'(ch));
    chk({tag, "_be"},  {24'd0, best_energy}, 32'(be));
    chk({tag, "_cv"},  {31'd0, channel_valid}, 32'd1);
    chk({tag, "_hop"}, {31'd0, hop_pulse}, 32'(hp));
  endtask

  initial begin
    logic [31:0] w_base;
    logic [31:0] w_d5;
    logic        saw_pulse;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_energy = '0;

    // 1. Reset state, and reset mid-scan
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ch", {30'd0, safest_channel}, 32'd0);
    chk("rst_cv", {31'd0, channel_valid}, 32'd0);
    chk("rst_be", {24'd0, best_energy}, 32'd0);
    chk("rst_hop", {31'd0, hop_pulse}, 32'd0);
    chk("rst_rdy", {31'd0, sample_ready}, 32'd1);

    w_base = pk(50, 20, 30, 40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid  = 1'b1;
      sample_energy = w_base;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk("scan_rdy_low", {31'd0, sample_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midscan_rdy", {31'd0, sample_ready}, 32'd1);
    chk("midscan_cv", {31'd0, channel_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hop_pulse || channel_valid) saw_pulse = 1'b1;
    end
    chk("midscan_no_decision", {31'd0, saw_pulse}, 32'd0);

    // 2. First acquisition
    do_reset();
    send_window(w_base, w_base, w_base, w_base);
    expect_out("acq", 1, 20, 1);
    @(negedge clk);
    chk("acq_pulse_1cyc", {31'd0, hop_pulse}, 32'd0);

    // 3. Tie -> lowest index; floor of average
    do_reset();
    send_window(pk(10,10,10,10), pk(10,10,10,10), pk(10,10,10,10), pk(10,10,10,10));
    expect_out("tie", 0, 10, 1);
    do_reset();
    send_window(pk(1,200,200,200), pk(2,200,200,200), pk(2,200,200,200), pk(2,200,200,200));
    expect_out("floor", 0, 1, 1);

    // 4. Hysteresis
    do_reset();
    send_window(w_base, w_base, w_base, w_base);
    expect_out("hy_acq", 1, 20, 1);
    send_window(w_base, w_base, w_base, w_base);
    expect_out("hy_hold1", 1, 20, 0);
    send_window(w_base, w_base, w_base, w_base);
    expect_out("hy_hold2", 1, 20, 0);
    send_window(pk(50,20,17,40), pk(50,20,17,40), pk(50,20,17,40), pk(50,20,17,40));
    expect_out("hy_17", 1, 20, 0);
    send_window(pk(50,20,15,40), pk(50,20,15,40), pk(50,20,15,40), pk(50,20,15,40));
    expect_out("hy_15", 2, 15, 1);

    // 5. Minimum dwell
    do_reset();
    w_d5 = pk(50, 20, 5, 40);
    send_window(w_base, w_base, w_base, w_base);
    expect_out("dw_w1", 1, 20, 1);
    send_window(w_d5, w_d5, w_d5, w_d5);
    expect_out("dw_w2", 1, 20, 0);
    send_window(w_d5, w_d5, w_d5, w_d5);
    expect_out("dw_w3", 1, 20, 0);
    send_window(w_d5, w_d5, w_d5, w_d5);
    expect_out("dw_w4", 2, 5, 1);

    // 6. Backpressure: valid held high, junk offered while not ready
    do_reset();
    for (int t = 0; t < 19; t++) begin
      @(negedge clk);
      if (t == 9) expect_out("bp_w1", 1, 30, 1);
      if (t == 18) begin
        expect_out("bp_w2", 1, 32, 0);
      end else begin
        chk($sformatf("bp_rdy_t%0d", t), {31'd0, sample_ready},
            32'((t < 4) || (t >= 9 && t < 13)));
        sample_valid = 1'b1;
        if (t < 4)                  sample_energy = pk(40, 30, 60, 50);
        else if (t >= 9 && t < 13)  sample_energy = pk(100, 32, 100, 100);
        else                        sample_energy = pk(0, 255, 255, 255);
      end
    end
    sample_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
